// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with handshake advance, redirects and a circular
// return-address stack that predicts return targets.
module pc_sequencer #(
  parameter int unsigned       ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
  parameter int unsigned       INSTR_BYTES = 4,
  parameter int unsigned       RAS_DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         fetch_ready,
  input  logic                         stall,
  input  logic                         redir_valid,
  input  logic [1:0]                   redir_type,
  input  logic [ADDR_W-1:0]            redir_base,
  input  logic [ADDR_W-1:0]            redir_offset,
  output logic [ADDR_W-1:0]            pc,
  output logic                         pc_valid,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         misalign,
  output logic                         ras_underflow
);

  localparam int unsigned       PtrW    = $clog2(RAS_DEPTH);
  localparam logic [ADDR_W-1:0] Step    = ADDR_W'(INSTR_BYTES);
  localparam logic [ADDR_W-1:0] LowMask = Step - 1'b1;
  localparam logic [PtrW:0]     Full    = (PtrW + 1)'(RAS_DEPTH);

  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
  logic [PtrW-1:0]   top_q, top_d;
  logic [PtrW:0]     count_q, count_d;
  logic [ADDR_W-1:0] pc_d, sum, target;
  logic              push, pop, mis_d, uf_d;

  always_comb begin
    sum     = redir_base + redir_offset;
    target  = sum & ~LowMask;
    pc_d    = pc;
    push    = 1'b0;
    pop     = 1'b0;
    mis_d   = 1'b0;
    uf_d    = 1'b0;
    top_d   = top_q;
    count_d = count_q;

    if (redir_valid) begin
      pc_d  = target;
      mis_d = |(sum & LowMask);
      unique case (redir_type)
        2'b10: push = 1'b1;
        2'b11: begin
          if (count_q != '0) begin
            // Predicted return: the computed target is not used, so no misalign.
            pc_d  = ras_q[top_q];
            pop   = 1'b1;
            mis_d = 1'b0;
          end else begin
            uf_d = 1'b1;
          end
        end
        default: ;
      endcase
    end else if (!stall && pc_valid && fetch_ready) begin
      pc_d = pc + Step;
    end

    if (push) begin
      top_d = top_q + 1'b1;
      if (count_q != Full) count_d = count_q + 1'b1;
    end
    if (pop) begin
      top_d   = top_q - 1'b1;
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc            <= RESET_VEC;
      pc_valid      <= 1'b0;
      misalign      <= 1'b0;
      ras_underflow <= 1'b0;
      top_q         <= '0;
      count_q       <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else begin
      pc            <= pc_d;
      pc_valid      <= 1'b1;
      misalign      <= mis_d;
      ras_underflow <= uf_d;
      top_q         <= top_d;
      count_q       <= count_d;
      // Wrapping top pointer makes a push on a full stack overwrite the oldest entry.
      if (push) ras_q[top_d] <= redir_base + Step;
    end
  end

  assign ras_count = count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus pushes model predictions, a monitor
// pops and compares whenever pc_valid is high.
module tb_pc_sequencer;

  localparam int unsigned IB    = 4;
  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  cnt;
    logic        mis;
    logic        uf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_ready = 1'b0, stall = 1'b0, redir_valid = 1'b0;
  logic [1:0]  redir_type = 2'b00;
  logic [31:0] redir_base = '0, redir_offset = '0;
  logic [31:0] pc;
  logic        pc_valid, misalign, ras_underflow;
  logic [2:0]  ras_count;

  int checks = 0;
  int errors = 0;

  exp_t        sb[$];
  logic [31:0] m_pc = '0;
  bit          m_valid = 1'b0;
  logic [31:0] m_ras[$];

  pc_sequencer #(
    .ADDR_W(32), .RESET_VEC(32'h0), .INSTR_BYTES(IB), .RAS_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .fetch_ready(fetch_ready), .stall(stall),
    .redir_valid(redir_valid), .redir_type(redir_type), .redir_base(redir_base),
    .redir_offset(redir_offset), .pc(pc), .pc_valid(pc_valid), .ras_count(ras_count),
    .misalign(misalign), .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle of inputs and predict the state after the next rising edge.
  task automatic step(input bit fr, input bit st, input bit rv, input logic [1:0] rt,
                      input logic [31:0] b, input logic [31:0] o);
    exp_t        e;
    logic [31:0] t, s;
    @(negedge clk);
    fetch_ready = fr; stall = st; redir_valid = rv; redir_type = rt;
    redir_base = b; redir_offset = o;
    e.mis = 1'b0;
    e.uf  = 1'b0;
    s = b + o;
    t = s - (s % IB);
    if (rv) begin
      if (rt == 2'b11 && m_ras.size() > 0) begin
        m_pc = m_ras.pop_back();
      end else begin
        m_pc  = t;
        e.mis = (s % IB) != 0;
        e.uf  = (rt == 2'b11);
        if (rt == 2'b10) begin
          m_ras.push_back(b + IB);
          if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
        end
      end
    end else if (!st && m_valid && fr) begin
      m_pc = m_pc + IB;
    end
    m_valid = 1'b1;
    e.pc  = m_pc;
    e.cnt = 3'(m_ras.size());
    sb.push_back(e);
  endtask

  // Asynchronous reset between edges; outputs must change without a clock edge.
  task automatic mid_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_pc", pc, 32'h0);
    chk("async_rst_valid", {31'b0, pc_valid}, 32'h0);
    chk("async_rst_count", {29'b0, ras_count}, 32'h0);
    m_pc = '0; m_valid = 1'b0; m_ras.delete();
    redir_valid = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (pc_valid) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output actual=pc %h required=no output", pc);
      end else begin
        e = sb.pop_front();
        chk("pc", pc, e.pc);
        chk("ras_count", {29'b0, ras_count}, {29'b0, e.cnt});
        chk("misalign", {31'b0, misalign}, {31'b0, e.mis});
        chk("ras_underflow", {31'b0, ras_underflow}, {31'b0, e.uf});
      end
    end
  end

  initial begin
    #17;
    chk("reset_valid", {31'b0, pc_valid}, 32'h0);
    chk("reset_pc", pc, 32'h0);
    chk("reset_flags", {30'b0, misalign, ras_underflow}, 32'h0);
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Sequential fetch, then back-pressure and stall.
    repeat (5) step(1, 0, 0, 2'b00, 0, 0);
    repeat (2) step(0, 0, 0, 2'b00, 0, 0);
    step(1, 1, 0, 2'b00, 0, 0);
    step(1, 0, 0, 2'b00, 0, 0);
    // Branch beats stall; misaligned target is truncated.
    step(1, 1, 1, 2'b00, 32'h100, 32'hFFFF_FFF0);
    step(1, 1, 1, 2'b00, 32'h100, 32'h3);
    step(0, 0, 0, 2'b00, 0, 0);
    // Nested call/return.
    step(1, 0, 1, 2'b10, 32'h10, 32'h1F0);
    step(1, 0, 1, 2'b10, 32'h204, 32'hFC);
    step(1, 0, 1, 2'b11, 0, 0);
    step(1, 0, 1, 2'b11, 0, 0);
    // Overflow then underflow.
    for (int i = 0; i < 5; i++) step(0, 0, 1, 2'b10, 32'h1000 * (i + 1), 32'h40);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 2'b11, 32'h500, 32'h4);
    // Wrap-around.
    step(0, 0, 1, 2'b01, 32'h0, 32'hFFFF_FFFC);
    step(1, 0, 0, 2'b00, 0, 0);
    step(1, 0, 0, 2'b00, 0, 0);
    mid_reset();

    for (int n = 0; n < 400; n++) begin
      logic [31:0] b, o;
      b = $urandom();
      if ($urandom_range(0, 1) == 1) b = b & 32'hFFFF_FFFC;
      o = 32'($urandom_range(0, 128)) - 32'd64;
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0),
           1'($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)), b, o);
      if (n == 200) mid_reset();
    end
    step(0, 0, 0, 2'b00, 0, 0);
    @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
